alu24_mem_stage: RTL and testbench

Execute/memory stage of the 24-bit single-cycle CPU: an ALU-control decoder, a 24-bit ALU and a byte-addressed data memory. It sits between the register file and the write-back mux. It turns ALUOp/funct/opcode into an ALU operation, computes the result and flags, and performs the load/store addressed by that result.

---
 rtl/alu24_mem_stage.sv | 117 +++++++++++
 tb/tb_alu24_mem_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu24_mem_stage.sv
// Execute/memory stage of the 24-bit CPU: ALU-control decode, 24-bit ALU and a
// byte-addressed big-endian data memory addressed by the ALU result.
module alu24_mem_stage #(
  parameter int MEM_BYTES = 128
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [1:0]  ALUOp,
  input  logic [3:0]  Funct,
  input  logic [3:0]  Opcode,
  input  logic [23:0] A,
  input  logic [23:0] B,
  input  logic [23:0] StoreData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [23:0] Result,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic [23:0] ReadData
);
  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b1010;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_XOR = 4'b0100;
  localparam logic [3:0] C_NOR = 4'b0101;
  localparam logic [3:0] C_SLT = 4'b1011;

  always_comb begin
    ALUCtrl = C_ADD;
    unique case (ALUOp)
      2'b00: ALUCtrl = C_ADD;
      2'b01: ALUCtrl = C_SUB;
      2'b10: begin
        case (Funct)
          4'b0000: ALUCtrl = C_ADD;
          4'b0001: ALUCtrl = C_SUB;
          4'b0010: ALUCtrl = C_AND;
          4'b0011: ALUCtrl = C_OR;
          4'b0100: ALUCtrl = C_XOR;
          4'b0101: ALUCtrl = C_NOR;
          4'b0110: ALUCtrl = C_SLT;
          default: ALUCtrl = C_ADD;
        endcase
      end
      2'b11: begin
        case (Opcode)
          4'b0100: ALUCtrl = C_ADD;
          4'b0101: ALUCtrl = C_SUB;
          4'b0110: ALUCtrl = C_AND;
          4'b0111: ALUCtrl = C_OR;
          4'b1000: ALUCtrl = C_SLT;
          default: ALUCtrl = C_ADD;
        endcase
      end
      default: ALUCtrl = C_ADD;
    endcase
  end

  logic [23:0] b_inv;
  logic [24:0] sum;
  logic        add_ovf;

  assign b_inv   = ALUCtrl[3] ? ~B : B;
  assign sum     = {1'b0, A} + {1'b0, b_inv} + {24'd0, ALUCtrl[3]};
  assign add_ovf = (A[23] == b_inv[23]) && (sum[23] != A[23]);

  always_comb begin
    Result   = 24'd0;
    Overflow = 1'b0;
    CarryOut = 1'b0;
    case (ALUCtrl[2:0])
      3'b000: Result = A & B;
      3'b001: Result = A | B;
      3'b010: begin
        Result   = sum[23:0];
        Overflow = add_ovf;
        CarryOut = sum[24];
      end
      // Signed less-than: sign of the difference corrected by its overflow.
      3'b011: begin
        Result   = {23'd0, sum[23] ^ add_ovf};
        CarryOut = sum[24];
      end
      3'b100: Result = A ^ B;
      3'b101: Result = ~(A | B);
      default: Result = 24'd0;
    endcase
  end

  assign Zero = (Result == 24'd0);

  // Address arithmetic is done in AW bits so the three byte lanes wrap naturally.
  logic [AW-1:0] addr0, addr1, addr2;
  logic [7:0]    mem_q [MEM_BYTES];

  assign addr0 = Result[AW-1:0];
  assign addr1 = addr0 + AW'(1);
  assign addr2 = addr0 + AW'(2);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= 8'd0;
    end else if (MemWrite) begin
      mem_q[addr0] <= StoreData[23:16];
      mem_q[addr1] <= StoreData[15:8];
      mem_q[addr2] <= StoreData[7:0];
    end
  end

  assign ReadData = MemRead ? {mem_q[addr0], mem_q[addr1], mem_q[addr2]} : 24'd0;

endmodule

// File: tb/tb_alu24_mem_stage.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops
// and compares the DUT's combinational outputs mid-cycle.
module tb_alu24_mem_stage;
  localparam int MB = 128;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  aluop;
  logic [3:0]  funct, opc;
  logic [23:0] a, b, sd;
  logic        mr, mw;
  logic [3:0]  ctrl;
  logic [23:0] res, rd;
  logic        zero, ovf, co;

  alu24_mem_stage #(.MEM_BYTES(MB)) dut (
    .Clock(clk), .Resetn(rstn), .ALUOp(aluop), .Funct(funct), .Opcode(opc),
    .A(a), .B(b), .StoreData(sd), .MemRead(mr), .MemWrite(mw),
    .ALUCtrl(ctrl), .Result(res), .Zero(zero), .Overflow(ovf), .CarryOut(co),
    .ReadData(rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [23:0] res;
    logic        z, ov, co;
    logic [23:0] rd;
  } exp_t;

  typedef enum {O_ADD, O_SUB, O_AND, O_OR, O_XOR, O_NOR, O_SLT} op_e;

  exp_t        sb_q[$];
  logic        stim_vld = 1'b0;
  int          checks = 0, failures = 0;
  logic [7:0]  mdl[MB];
  logic        pend_wr = 1'b0;
  int          pend_addr;
  logic [23:0] pend_data;

  function automatic op_e decode(input logic [1:0] op, input logic [3:0] f, input logic [3:0] o);
    if (op == 2'b00) return O_ADD;
    if (op == 2'b01) return O_SUB;
    if (op == 2'b10) begin
      case (f)
        4'd1: return O_SUB;  4'd2: return O_AND; 4'd3: return O_OR;
        4'd4: return O_XOR;  4'd5: return O_NOR; 4'd6: return O_SLT;
        default: return O_ADD;
      endcase
    end
    case (o)
      4'd5: return O_SUB; 4'd6: return O_AND; 4'd7: return O_OR; 4'd8: return O_SLT;
      default: return O_ADD;
    endcase
  endfunction

  function automatic longint sx(input logic [23:0] v);
    return v[23] ? longint'(v) - 64'sd16777216 : longint'(v);
  endfunction

  function automatic logic out_of_range(input longint v);
    return (v > 64'sd8388607) || (v < -64'sd8388608);
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [3:0] f, input logic [3:0] o,
                                 input logic [23:0] x, input logic [23:0] y);
    exp_t   e;
    op_e    k;
    longint ux, uy;
    k  = decode(op, f, o);
    ux = longint'(x);
    uy = longint'(y);
    e  = '0;
    case (k)
      O_ADD: begin
        e.ctrl = 4'b0010; e.res = 24'((ux + uy) % 16777216);
        e.co = (ux + uy) >= 16777216; e.ov = out_of_range(sx(x) + sx(y));
      end
      O_SUB: begin
        e.ctrl = 4'b1010; e.res = 24'((ux - uy + 16777216) % 16777216);
        e.co = ux >= uy; e.ov = out_of_range(sx(x) - sx(y));
      end
      O_AND: begin e.ctrl = 4'b0000; e.res = x & y; end
      O_OR:  begin e.ctrl = 4'b0001; e.res = x | y; end
      O_XOR: begin e.ctrl = 4'b0100; e.res = x ^ y; end
      O_NOR: begin e.ctrl = 4'b0101; e.res = ~(x | y); end
      O_SLT: begin
        e.ctrl = 4'b1011; e.res = (sx(x) < sx(y)) ? 24'd1 : 24'd0; e.co = ux >= uy;
      end
      default: e = '0;
    endcase
    e.z = (e.res == 24'd0);
    return e;
  endfunction

  function automatic logic [23:0] mdl_word(input int addr);
    return {mdl[addr % MB], mdl[(addr + 1) % MB], mdl[(addr + 2) % MB]};
  endfunction

  // One cycle of stimulus: commit the previous cycle's store, drive, predict.
  task automatic cyc(input logic [1:0] op, input logic [3:0] f, input logic [3:0] o,
                     input logic [23:0] x, input logic [23:0] y, input logic [23:0] d,
                     input logic rdn, input logic wrn, input logic rst_n);
    exp_t e;
    @(posedge clk);
    #1;
    if (pend_wr) begin
      mdl[pend_addr]          = pend_data[23:16];
      mdl[(pend_addr + 1) % MB] = pend_data[15:8];
      mdl[(pend_addr + 2) % MB] = pend_data[7:0];
    end
    aluop = op; funct = f; opc = o; a = x; b = y; sd = d; mr = rdn; mw = wrn; rstn = rst_n;
    if (!rst_n) for (int i = 0; i < MB; i++) mdl[i] = 8'd0;
    e = model(op, f, o, x, y);
    e.rd = rdn ? mdl_word(int'(e.res % MB)) : 24'd0;
    pend_wr   = wrn && rst_n;
    pend_addr = int'(e.res % MB);
    pend_data = d;
    sb_q.push_back(e);
    stim_vld = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (stim_vld) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("alu_ctrl", {20'd0, ctrl}, {20'd0, e.ctrl});
        chk("result",   res, e.res);
        chk("zero",     {23'd0, zero}, {23'd0, e.z});
        chk("overflow", {23'd0, ovf},  {23'd0, e.ov});
        chk("carry",    {23'd0, co},   {23'd0, e.co});
        chk("read_data", rd, e.rd);
      end
    end
  end

  initial begin
    logic [23:0] ra, rb;
    rstn = 1'b0; aluop = '0; funct = '0; opc = '0; a = '0; b = '0; sd = '0; mr = 1'b0; mw = 1'b0;
    for (int i = 0; i < MB; i++) mdl[i] = 8'd0;
    repeat (2) @(posedge clk);
    // Reset state: memory reads zero everywhere.
    cyc(2'b00, 4'd0, 4'd0, 24'd40, 24'd0, 24'd0, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 4'd0, 4'd0, 24'd7, 24'd0, 24'd0, 1'b1, 1'b0, 1'b1);
    // Directed arithmetic corners.
    cyc(2'b10, 4'd0, 4'd0, 24'h7FFFFF, 24'd1, 24'd0, 1'b0, 1'b0, 1'b1);
    cyc(2'b01, 4'd0, 4'd0, 24'h123456, 24'h123456, 24'd0, 1'b0, 1'b0, 1'b1);
    cyc(2'b10, 4'd6, 4'd0, 24'hFFFFFF, 24'd1, 24'd0, 1'b0, 1'b0, 1'b1);
    cyc(2'b10, 4'd6, 4'd0, 24'd1, 24'hFFFFFF, 24'd0, 1'b0, 1'b0, 1'b1);
    cyc(2'b10, 4'd6, 4'd0, 24'h7FFFFF, 24'h800000, 24'd0, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 4'd0, 4'd6, 24'hF0F0F0, 24'h00FF00, 24'd0, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 4'd0, 4'd15, 24'hF0F0F0, 24'h00FF00, 24'd0, 1'b0, 1'b0, 1'b1);
    cyc(2'b01, 4'd0, 4'd0, 24'h800000, 24'd1, 24'd0, 1'b0, 1'b0, 1'b1);
    // Store at 15, read back at 15/16, same-cycle read-and-write shows old data.
    cyc(2'b00, 4'd0, 4'd0, 24'd10, 24'd5, 24'hABCDEF, 1'b0, 1'b1, 1'b1);
    cyc(2'b00, 4'd0, 4'd0, 24'd10, 24'd5, 24'd0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 4'd0, 4'd0, 24'd11, 24'd5, 24'd0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 4'd0, 4'd0, 24'd10, 24'd5, 24'h112233, 1'b1, 1'b1, 1'b1);
    cyc(2'b00, 4'd0, 4'd0, 24'd10, 24'd5, 24'd0, 1'b1, 1'b0, 1'b1);
    // Wrapping store at 126 and reads across the wrap.
    cyc(2'b00, 4'd0, 4'd0, 24'd126, 24'd0, 24'h445566, 1'b0, 1'b1, 1'b1);
    cyc(2'b00, 4'd0, 4'd0, 24'd126, 24'd0, 24'd0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 4'd0, 4'd0, 24'd0, 24'd0, 24'd0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 4'd0, 4'd0, 24'd127, 24'd256, 24'd0, 1'b1, 1'b0, 1'b1);
    // Mid-cycle reset clears immediately; a write edge under reset is dropped.
    cyc(2'b00, 4'd0, 4'd0, 24'd15, 24'd0, 24'd0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 4'd0, 4'd0, 24'd15, 24'd0, 24'h777777, 1'b1, 1'b1, 1'b0);
    cyc(2'b00, 4'd0, 4'd0, 24'd15, 24'd0, 24'h777777, 1'b1, 1'b1, 1'b0);
    cyc(2'b00, 4'd0, 4'd0, 24'd15, 24'd0, 24'd0, 1'b1, 1'b0, 1'b1);
    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ra = $urandom_range(0, 3) == 0 ? 24'($urandom_range(0, 2 * MB)) : 24'($urandom);
      rb = $urandom_range(0, 3) == 0 ? 24'($urandom_range(0, 8)) : 24'($urandom);
      if ($urandom_range(0, 9) == 0) rb = ra;
      cyc(2'($urandom), 4'($urandom), 4'($urandom), ra, rb, 24'($urandom),
          1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 60) != 0);
    end
    @(posedge clk);
    #1 stim_vld = 1'b0;
    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
